wm8731_cfg_seq: RTL

- Configuration sequencer for the WM8731 codec, placed between the system bus and the i2c controller.
- After reset it plays a fixed power-up register table into the codec over the i2c controller's write handshake. It retries transfers that fail and flags when the codec is configured.
- Once configured, it accepts single runtime register writes from the host, such as volume or mute.

---
 rtl/wm8731_cfg_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wm8731_cfg_seq.sv
// WM8731 configuration sequencer: plays the power-up register table into the codec
// through the i2c controller's write handshake, then serves single host register writes.
module wm8731_cfg_seq #(
  parameter logic [7:0] DEV_ADDR   = 8'h34,
  parameter int         NUM_REGS   = 11,
  parameter int         PWR_DLY    = 50000,
  parameter int         GAP_CYCLES = 1000,
  parameter int         MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic        wr_i2c,
  output logic [23:0] i2c_packet,
  input  logic        i2c_idle,
  input  logic        i2c_done_tick,
  input  logic        i2c_fail,
  input  logic        restart,
  input  logic        cfg_wr,
  input  logic [6:0]  cfg_addr,
  input  logic [8:0]  cfg_data,
  output logic        cfg_ready,
  output logic        cfg_done_tick,
  output logic        cfg_err_tick,
  output logic        init_done,
  output logic        init_fail
);

  localparam int PWR_W = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int IDX_W = $clog2(NUM_REGS + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWR_DLY - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_REGS);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {S_PWR, S_ISSUE, S_WAIT, S_GAP, S_READY, S_ERR} state_t;
  typedef enum logic {M_INIT, M_HOST} mode_t;

  state_t           state;
  mode_t            mode;
  logic [PWR_W-1:0] pwr_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [IDX_W-1:0] idx;
  logic [RTY_W-1:0] retry;
  logic [15:0]      host_word;

  // Power-up table as {reg_addr[6:0], reg_data[8:0]}.
  function automatic logic [15:0] init_word(input logic [IDX_W-1:0] i);
    case (int'(i))
      0:       init_word = {7'd15, 9'h000};
      1:       init_word = {7'd0,  9'h017};
      2:       init_word = {7'd1,  9'h017};
      3:       init_word = {7'd2,  9'h079};
      4:       init_word = {7'd3,  9'h079};
      5:       init_word = {7'd4,  9'h012};
      6:       init_word = {7'd5,  9'h000};
      7:       init_word = {7'd6,  9'h000};
      8:       init_word = {7'd7,  9'h00A};
      9:       init_word = {7'd8,  9'h000};
      10:      init_word = {7'd9,  9'h001};
      default: init_word = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (state == S_READY && cfg_wr && !restart)
      host_word <= {cfg_addr, cfg_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_PWR;
      mode          <= M_INIT;
      pwr_cnt       <= '0;
      gap_cnt       <= '0;
      idx           <= '0;
      retry         <= '0;
      wr_i2c        <= 1'b0;
      i2c_packet    <= '0;
      cfg_ready     <= 1'b0;
      cfg_done_tick <= 1'b0;
      cfg_err_tick  <= 1'b0;
      init_done     <= 1'b0;
      init_fail     <= 1'b0;
    end else begin
      wr_i2c        <= 1'b0;
      cfg_done_tick <= 1'b0;
      cfg_err_tick  <= 1'b0;
      case (state)
        S_PWR: begin
          if (pwr_cnt == PWR_LAST) begin
            pwr_cnt <= '0;
            mode    <= M_INIT;
            idx     <= '0;
            state   <= S_ISSUE;
          end else begin
            pwr_cnt <= pwr_cnt + PWR_W'(1);
          end
        end
        S_ISSUE: begin
          if (i2c_idle) begin
            wr_i2c     <= 1'b1;
            i2c_packet <= {DEV_ADDR, (mode == M_HOST) ? host_word : init_word(idx)};
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A coincident done and fail is treated as a failed transfer.
          if (i2c_fail) begin
            gap_cnt <= '0;
            if (retry < RTY_MAX) begin
              retry <= retry + RTY_W'(1);
              state <= S_GAP;
            end else if (mode == M_INIT) begin
              init_fail <= 1'b1;
              state     <= S_ERR;
            end else begin
              cfg_err_tick <= 1'b1;
              retry        <= '0;
              state        <= S_GAP;
            end
          end else if (i2c_done_tick) begin
            gap_cnt <= '0;
            retry   <= '0;
            if (mode == M_INIT) idx <= idx + IDX_W'(1);
            else                cfg_done_tick <= 1'b1;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            // A nonzero retry count means the last packet still has to be resent.
            if (retry != '0) begin
              state <= S_ISSUE;
            end else if (mode == M_INIT && idx < IDX_END) begin
              state <= S_ISSUE;
            end else begin
              if (mode == M_INIT) init_done <= 1'b1;
              cfg_ready <= 1'b1;
              state     <= S_READY;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_READY: begin
          if (restart) begin
            init_done <= 1'b0;
            init_fail <= 1'b0;
            idx       <= '0;
            retry     <= '0;
            pwr_cnt   <= '0;
            cfg_ready <= 1'b0;
            state     <= S_PWR;
          end else if (cfg_wr) begin
            mode      <= M_HOST;
            cfg_ready <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ERR: begin
          if (restart) begin
            init_done <= 1'b0;
            init_fail <= 1'b0;
            idx       <= '0;
            retry     <= '0;
            pwr_cnt   <= '0;
            state     <= S_PWR;
          end
        end
        default: state <= S_PWR;
      endcase
    end
  end

endmodule
